// File: rtl/instruction_sequencer.sv
// instruction_sequencer: records direction/torque instructions and plays them back
// one per step interval, with pause/resume, looping, undo, abort and auto-run.
module instruction_sequencer #(
  parameter int INSTR_W     = 4,
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int AUTO_RUN    = 1
) (
  input  logic                       CLOCK50,
  input  logic                       rst_n,
  input  logic                       save,
  input  logic                       execute,
  input  logic                       delete,
  input  logic                       clear,
  input  logic                       loop_en,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       running,
  output logic                       paused,
  output logic                       step_done,
  output logic                       seq_done
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t             state, state_n;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [CW-1:0]      count_n;
  logic [IW-1:0]      idx_n;
  logic [TW-1:0]      timer, timer_n;
  logic               loop_q, we, load, last;

  assign last        = CW'(step_idx) + CW'(1) == count;
  assign empty       = count == '0;
  assign full        = count == CW'(DEPTH);
  assign running     = state == RUN;
  assign paused      = state == PAUSE;
  assign instr_valid = running;
  assign step_done   = running && timer == '0;
  // loop_en is registered so the wrap decision and seq_done never see a raw input
  assign seq_done    = step_done && last && !loop_q;

  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = step_idx;
    timer_n = timer;
    we      = 1'b0;
    load    = 1'b0;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
      idx_n   = '0;
      timer_n = '0;
    end else begin
      case (state)
        IDLE:
          if ((AUTO_RUN != 0 && full) || (execute && !empty)) begin
            state_n = RUN;
            idx_n   = '0;
            timer_n = RELOAD;
            load    = 1'b1;
          end else if (save) begin
            we      = !full;
            count_n = full ? count : count + CW'(1);
          end else if (delete && !empty) begin
            count_n = count - CW'(1);
          end
        RUN:
          // the pausing cycle still counts toward the step; a step paused at zero gets one more cycle
          if (execute) begin
            state_n = PAUSE;
            timer_n = step_done ? timer : timer - TW'(1);
          end else if (!step_done) begin
            timer_n = timer - TW'(1);
          end else if (!last || loop_q) begin
            idx_n   = last ? '0 : step_idx + IW'(1);
            timer_n = RELOAD;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
            count_n = '0;
            idx_n   = '0;
          end
        PAUSE:   state_n = execute ? RUN : PAUSE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      step_idx  <= '0;
      timer     <= '0;
      loop_q    <= 1'b0;
      instr_out <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      step_idx <= idx_n;
      timer    <= timer_n;
      loop_q   <= loop_en;
      if (load) instr_out <= mem[idx_n];
    end
  end

  always_ff @(posedge CLOCK50) begin
    if (we) mem[IW'(count)] <= instr_in;
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed scenarios for record, undo, full/auto-run,
// looping, pause/resume, abort and asynchronous reset.
module tb_instruction_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, save = 1'b0, execute = 1'b0, del = 1'b0, clear = 1'b0, loop_en = 1'b0;
  logic [3:0] instr = '0;
  logic [3:0] instr_out, instr_out_b;
  logic [1:0] step_idx, step_idx_b;
  logic [2:0] count, count_b;
  logic       instr_valid, empty, full, running, paused, step_done, seq_done;
  logic       instr_valid_b, empty_b, full_b, running_b, paused_b, step_done_b, seq_done_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.INSTR_W(4), .DEPTH(4), .STEP_CYCLES(3), .AUTO_RUN(0)) dut (
    .CLOCK50(clk), .rst_n(rst_n), .save(save), .execute(execute), .delete(del), .clear(clear),
    .loop_en(loop_en), .instr_in(instr), .instr_out(instr_out), .instr_valid(instr_valid),
    .step_idx(step_idx), .count(count), .empty(empty), .full(full), .running(running),
    .paused(paused), .step_done(step_done), .seq_done(seq_done));

  instruction_sequencer #(.INSTR_W(4), .DEPTH(4), .STEP_CYCLES(3), .AUTO_RUN(1)) dut_auto (
    .CLOCK50(clk), .rst_n(rst_n), .save(save), .execute(execute), .delete(del), .clear(clear),
    .loop_en(loop_en), .instr_in(instr), .instr_out(instr_out_b), .instr_valid(instr_valid_b),
    .step_idx(step_idx_b), .count(count_b), .empty(empty_b), .full(full_b), .running(running_b),
    .paused(paused_b), .step_done(step_done_b), .seq_done(seq_done_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_save(input logic [3:0] v);
    instr = v;
    save = 1'b1;
    tick;
    save = 1'b0;
  endtask

  task automatic do_exec;
    execute = 1'b1;
    tick;
    execute = 1'b0;
  endtask

  task automatic do_delete;
    del = 1'b1;
    tick;
    del = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({instr_out, instr_valid, step_idx, count, empty, full, running, paused, step_done, seq_done} !== 16'b0000_0_00_000_1_00000)
      begin errors++; $display("FAIL reset: out=%h valid=%b idx=%0d count=%0d empty=%b full=%b run=%b pause=%b sd=%b qd=%b, expected all 0 except empty=1",
        instr_out, instr_valid, step_idx, count, empty, full, running, paused, step_done, seq_done); end
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_playback;
    logic [3:0] exp_v [3] = '{4'h5, 4'h9, 4'hE};
    do_save(4'h5); do_save(4'h9); do_save(4'hE);
    checks++;
    if (count !== 3'd3 || empty !== 1'b0) begin errors++; $display("FAIL record_count: count=%0d empty=%b, expected 3 0", count, empty); end
    do_exec;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (instr_out !== exp_v[i/3] || instr_valid !== 1'b1)
        begin errors++; $display("FAIL play[%0d]: out=%h valid=%b, expected %h 1", i, instr_out, instr_valid, exp_v[i/3]); end
      checks++;
      if (step_done !== (i % 3 == 2) || seq_done !== (i == 8))
        begin errors++; $display("FAIL play_pulse[%0d]: step_done=%b seq_done=%b, expected %b %b", i, step_done, seq_done, i % 3 == 2, i == 8); end
      tick;
    end
    checks++;
    if (running !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL play_end: running=%b count=%0d empty=%b, expected 0 0 1", running, count, empty); end
  endtask

  task automatic test_delete;
    logic [3:0] exp_v [3] = '{4'h1, 4'h2, 4'h7};
    do_save(4'h1); do_save(4'h2); do_save(4'h3);
    do_delete;
    checks++;
    if (count !== 3'd2) begin errors++; $display("FAIL delete_count: count=%0d, expected 2", count); end
    do_save(4'h7);
    do_exec;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (instr_out !== exp_v[i/3]) begin errors++; $display("FAIL undo_play[%0d]: out=%h, expected %h", i, instr_out, exp_v[i/3]); end
      tick;
    end
    do_delete;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL delete_empty: count=%0d empty=%b, expected 0 1", count, empty); end
    instr = 4'h9;
    save = 1'b1;
    del = 1'b1;
    tick;
    save = 1'b0;
    del = 1'b0;
    checks++;
    if (count !== 3'd1) begin errors++; $display("FAIL save_over_delete: count=%0d, expected 1", count); end
    do_clear;
  endtask

  task automatic test_full_autorun;
    do_reset;
    do_save(4'h3); do_save(4'h6); do_save(4'hC); do_save(4'hF);
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full: count=%0d full=%b, expected 4 1", count, full); end
    checks++;
    if (full_b !== 1'b1 || running_b !== 1'b0) begin errors++; $display("FAIL auto_wait: full=%b running=%b, expected 1 0", full_b, running_b); end
    do_save(4'h8);
    checks++;
    if (count !== 3'd4 || running !== 1'b0) begin errors++; $display("FAIL save_when_full: count=%0d running=%b, expected 4 0", count, running); end
    checks++;
    if (running_b !== 1'b1 || instr_out_b !== 4'h3) begin errors++; $display("FAIL auto_run: running=%b out=%h, expected 1 3", running_b, instr_out_b); end
    do_exec;
    checks++;
    if (running !== 1'b1 || instr_out !== 4'h3) begin errors++; $display("FAIL full_play: running=%b out=%h, expected 1 3", running, instr_out); end
    do_clear;
    checks++;
    if (running !== 1'b0 || count !== 3'd0 || running_b !== 1'b0) begin errors++; $display("FAIL full_clear: running=%b count=%0d running_b=%b, expected 0 0 0", running, count, running_b); end
  endtask

  task automatic test_loop;
    logic [3:0] exp_v [2] = '{4'hA, 4'hB};
    loop_en = 1'b1;
    do_save(4'hA); do_save(4'hB);
    do_exec;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (instr_out !== exp_v[(i/3)%2] || seq_done !== (i == 11) || running !== 1'b1)
        begin errors++; $display("FAIL loop[%0d]: out=%h seq_done=%b running=%b, expected %h %b 1", i, instr_out, seq_done, running, exp_v[(i/3)%2], i == 11); end
      if (i == 9) loop_en = 1'b0;
      tick;
    end
    checks++;
    if (running !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL loop_end: running=%b empty=%b, expected 0 1", running, empty); end
  endtask

  task automatic test_pause;
    do_save(4'h4); do_save(4'h5); do_save(4'h6);
    do_exec;
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (step_idx !== 2'd1 || instr_out !== 4'h5) begin errors++; $display("FAIL pre_pause: idx=%0d out=%h, expected 1 5", step_idx, instr_out); end
    do_exec;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (paused !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 4'h5 || step_idx !== 2'd1 || step_done !== 1'b0)
        begin errors++; $display("FAIL paused[%0d]: paused=%b valid=%b out=%h idx=%0d sd=%b, expected 1 0 5 1 0", k, paused, instr_valid, instr_out, step_idx, step_done); end
      if (k < 9) tick;
    end
    do_exec;
    checks++;
    if (running !== 1'b1 || instr_out !== 4'h5 || step_done !== 1'b1)
      begin errors++; $display("FAIL resume: running=%b out=%h sd=%b, expected 1 5 1", running, instr_out, step_done); end
    tick;
    checks++;
    if (step_idx !== 2'd2 || instr_out !== 4'h6 || step_done !== 1'b0)
      begin errors++; $display("FAIL resume_adv: idx=%0d out=%h sd=%b, expected 2 6 0", step_idx, instr_out, step_done); end
  endtask

  task automatic test_clear_reset;
    do_clear;
    checks++;
    if (running !== 1'b0 || count !== 3'd0 || step_idx !== 2'd0 || seq_done !== 1'b0 || empty !== 1'b1)
      begin errors++; $display("FAIL clear: running=%b count=%0d idx=%0d seq_done=%b empty=%b, expected 0 0 0 0 1", running, count, step_idx, seq_done, empty); end
    do_save(4'hD);
    do_exec;
    do_exec;
    checks++;
    if (paused !== 1'b1) begin errors++; $display("FAIL pause_before_reset: paused=%b, expected 1", paused); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_out, instr_valid, step_idx, count, empty, full, running, paused, step_done, seq_done} !== 16'b0000_0_00_000_1_00000)
      begin errors++; $display("FAIL async_reset: out=%h valid=%b idx=%0d count=%0d empty=%b run=%b pause=%b, expected 0 0 0 0 1 0 0",
        instr_out, instr_valid, step_idx, count, empty, running, paused); end
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_playback;
    test_delete;
    test_full_autorun;
    test_loop;
    test_pause;
    test_clear_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Parametrised record/playback sequencer for robot motion instructions. It replaces the fixed save/execute FSM and its external FIFO and countdown with one block. Instructions (direction + torque codes) are recorded into an internal buffer. They are then played back one per step interval to the torque and direction display blocks. Adds pause/resume, loop playback, abort-clear, optional auto-run on full, and status/step outputs.

Parameters:
INSTR_W, 4, instruction width in bits (default: [3:2] torque, [1:0] direction).
DEPTH, 8, buffer entries; must be at least 2.
STEP_CYCLES, 50_000_000, clock cycles each instruction is presented (1 s at 50 MHz); must be at least 2.
AUTO_RUN, 1, if 1, IDLE moves to RUN automatically when the buffer becomes full.

Ports:
CLOCK50  in  1  system clock
rst_n  in  1  asynchronous active-low reset
save  in  1  single-cycle pulse (already debounced): record instr_in
execute  in  1  pulse: start playback / pause / resume
delete  in  1  pulse: remove most recently recorded entry
clear  in  1  pulse: abort and empty buffer
loop_en  in  1  level, sampled at each wrap decision: 1 = repeat sequence
instr_in  in  INSTR_W  instruction to record
instr_out  out  INSTR_W  instruction being played
instr_valid  out  1  high only in RUN
step_idx  out  $clog2(DEPTH)  index of instruction being played
count  out  $clog2(DEPTH+1)  number of stored entries
empty  out  1  count==0
full  out  1  count==DEPTH
running  out  1  state==RUN
paused  out  1  state==PAUSE
step_done  out  1  one-cycle pulse at the end of each step
seq_done  out  1  one-cycle pulse when a one-shot sequence completes

Behaviour:
- Reset (async, rst_n=0): state IDLE, count=0, write/read pointers 0, timer 0. All outputs 0 except empty=1. instr_out=0.
- Buffer: linear array, entry 0 is played first. The write pointer equals count. The buffer contents need no reset.
- States: IDLE, RUN, PAUSE.
- Priority per cycle: clear > execute > save > delete. Inputs that do not apply in the current state are ignored, with no side effects.
- clear (any state): next cycle state=IDLE, count=0, step_idx=0, timer=0. No seq_done pulse.
- IDLE + save, !full: mem[count]<=instr_in; count+1.
  - save while full: ignored.
  - If AUTO_RUN and the write makes count==DEPTH: enter RUN on the following cycle.
- IDLE + delete, !empty: count-1 (LIFO undo). Ignored when empty, or when save is pulsed in the same cycle.
- IDLE + execute, !empty: RUN next cycle, step_idx=0, timer=STEP_CYCLES-1.
  - execute while empty: ignored.
  - execute in the same cycle as save: execute wins (save is dropped).
- RUN:
  - instr_out=mem[step_idx] (registered; valid in the same cycle running is high). instr_valid=1.
  - Timer decrements each cycle. When timer==0, step_done=1 for that cycle, and:
    - step_idx<count-1: step_idx+1, timer reloaded to STEP_CYCLES-1.
    - last entry and loop_en=1: step_idx=0, timer reloaded; buffer kept.
    - last entry and loop_en=0: seq_done=1; next state IDLE; count=0 (sequence consumed).
  - Each step lasts exactly STEP_CYCLES cycles.
- RUN + execute: PAUSE. Timer and step_idx freeze; instr_valid=0; instr_out holds its value.
  - If timer==0 in the same cycle, execute wins and the step is not advanced.
- PAUSE + execute: RUN; the timer resumes from the frozen value.
  - save/delete in PAUSE: ignored.
- Displays key their enable off instr_valid, so a paused sequence blanks the LEDs and HEX outputs.
- No combinational path from any input to any output.

Test Plan:
(DEPTH=4, STEP_CYCLES=3, AUTO_RUN=0 unless stated)
1. Reset, then save 0x5, 0x9, 0xE -> count=3, empty=0. execute -> instr_out 0x5, 0x9, 0xE, each valid exactly 3 cycles. step_done pulses 3 times. seq_done once on the final step. Then IDLE, count=0, empty=1.
2. Save 0x1, 0x2, 0x3, delete -> count=2. Save 0x7 -> playback is 0x1, 0x2, 0x7. delete on empty buffer -> count stays 0.
3. Save 4 entries, then a 5th save -> full=1, count=4, 5th ignored. With AUTO_RUN=1, the 4th save alone -> running=1 two cycles later without execute.
4. loop_en=1, 2 entries -> 0xA, 0xB, 0xA, 0xB…, no seq_done. Drop loop_en during the 2nd 0xB step -> seq_done at its end, then IDLE.
5. During RUN on step 1, cycle 2 of 3: execute -> paused=1, instr_valid=0 for 10 cycles. execute -> step 1 runs exactly 1 more cycle before advancing.
6. clear mid-RUN -> IDLE next cycle, count=0, no seq_done. Assert rst_n=0 mid-PAUSE -> all outputs at reset values immediately, without waiting for a clock edge.
